// File: rtl/char_engine_arbiter.sv
// Round-robin arbiter sharing one character-render engine among N_REQ glyph producers.
// Issues a one-cycle start pulse, waits for done (or watchdog timeout), then acks the owner.
module char_engine_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned TO_CYC = 65535
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               init_done,
    input  logic [N_REQ-1:0]   req,
    input  logic [7*N_REQ-1:0] req_ascii,
    input  logic [9*N_REQ-1:0] req_x,
    input  logic [9*N_REQ-1:0] req_y,
    input  logic [N_REQ-1:0]   req_size,
    output logic [N_REQ-1:0]   ack,
    output logic               ack_err,
    output logic               show_char_flag,
    input  logic               show_char_done,
    output logic [6:0]         ascii_num,
    output logic [8:0]         start_x,
    output logic [8:0]         start_y,
    output logic               en_size,
    output logic               busy
);

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned WW = $clog2(TO_CYC + 1);

    typedef enum logic [2:0] {StIdle, StArb, StIssue, StBusy, StDone} state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    win_q, win_d;
    logic [N_REQ-1:0] mask_q, mask_d;
    logic [WW-1:0]    wd_q, wd_d;
    logic             err_q, err_d;
    logic             found;
    logic [PW-1:0]    win_idx;
    logic [N_REQ-1:0] req_eff;
    logic             timeout;
    logic             load;

    // The producer acked last cycle has not yet had a chance to drop or advance its request.
    assign req_eff = req & ~mask_q;
    assign timeout = (wd_q == WW'(TO_CYC - 1));
    assign load    = init_done && (state_q == StArb) && found;

    always_comb begin : rr_pick
        logic [PW-1:0] idx;
        idx     = '0;
        found   = 1'b0;
        win_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = PW'((32'(ptr_q) + i) % N_REQ);
            if (!found && req_eff[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            win_q   <= '0;
            mask_q  <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            mask_q  <= mask_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ascii_num <= '0;
            start_x   <= '0;
            start_y   <= '0;
            en_size   <= 1'b0;
        end else if (load) begin
            ascii_num <= req_ascii[7*32'(win_idx) +: 7];
            start_x   <= req_x[9*32'(win_idx) +: 9];
            start_y   <= req_y[9*32'(win_idx) +: 9];
            en_size   <= req_size[win_idx];
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        err_d   = err_q;
        mask_d  = '0;
        if (state_q == StDone) begin
            mask_d[win_q] = 1'b1;
        end
        // Counts from the flag cycle, so timeout lands the ack exactly TO_CYC cycles after it.
        wd_d = ((state_q == StIssue) || (state_q == StBusy)) ? wd_q + 1'b1 : '0;
        if (!init_done) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  state_d = StArb;
                StArb: begin
                    if (found) begin
                        win_d   = win_idx;
                        ptr_d   = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
                        state_d = StIssue;
                    end
                end
                StIssue: state_d = StBusy;
                StBusy: begin
                    if (show_char_done) begin
                        err_d   = 1'b0;
                        state_d = StDone;
                    end else if (timeout) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end
                end
                StDone:  state_d = StArb;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        ack = '0;
        if (init_done && (state_q == StDone)) begin
            ack[win_q] = 1'b1;
        end
        ack_err        = init_done && (state_q == StDone) && err_q;
        show_char_flag = init_done && (state_q == StIssue);
        busy           = (state_q == StIssue) || (state_q == StBusy) || (state_q == StDone);
    end

endmodule

// File: tb/tb_char_engine_arbiter.sv
// Directed bench for char_engine_arbiter: the bench plays the producers and the render engine.
module tb_char_engine_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_done;
    logic [3:0]  req;
    logic [27:0] req_ascii;
    logic [35:0] req_x;
    logic [35:0] req_y;
    logic [3:0]  req_size;
    logic [3:0]  ack;
    logic        ack_err;
    logic        show_char_flag;
    logic        done;
    logic [6:0]  ascii_num;
    logic [8:0]  start_x;
    logic [8:0]  start_y;
    logic        en_size;
    logic        busy;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    char_engine_arbiter #(
        .N_REQ (4),
        .TO_CYC(20)
    ) dut (
        .sys_clk       (clk),
        .sys_rst_n     (rst_n),
        .init_done     (init_done),
        .req           (req),
        .req_ascii     (req_ascii),
        .req_x         (req_x),
        .req_y         (req_y),
        .req_size      (req_size),
        .ack           (ack),
        .ack_err       (ack_err),
        .show_char_flag(show_char_flag),
        .show_char_done(done),
        .ascii_num     (ascii_num),
        .start_x       (start_x),
        .start_y       (start_y),
        .en_size       (en_size),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        init_done = 1'b0;
        req       = '0;
        done      = 1'b0;
        repeat (2) tick();
        check("rst_flag", 32'(show_char_flag), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ascii", 32'(ascii_num), 32'd0);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_flag();
        int w;
        w = 0;
        while (!show_char_flag && w < 50) begin
            tick();
            w++;
        end
        check("flag_wait", 32'(show_char_flag), 32'd1);
    endtask

    // Serves one glyph: engine pulses done lat cycles after the flag (lat=0: never).
    task automatic glyph(input int lat, output logic [3:0] a, output logic e, output int n,
                         output logic [6:0] asc);
        a   = '0;
        e   = 1'b0;
        n   = 0;
        asc = '0;
        wait_flag();
        if (!show_char_flag) return;
        asc = ascii_num;
        while (n < 100) begin
            tick();
            n++;
            done = 1'b0;
            if (ack != 4'd0) begin
                a = ack;
                e = ack_err;
                break;
            end
            if (n == lat) done = 1'b1;
        end
    endtask

    initial begin
        logic [3:0] a;
        logic       e;
        int         n;
        logic [6:0] asc;
        logic       seen;
        logic       stable;
        int         cnt;
        logic [3:0] exp_order[6];

        req_ascii = '0;
        req_x     = '0;
        req_y     = '0;
        req_size  = '0;
        do_reset();

        // Idle with init_done and no requests.
        init_done = 1'b1;
        seen      = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (show_char_flag || (ack != 4'd0) || busy) seen = 1'b1;
        end
        check("idle_quiet", 32'(seen), 32'd0);

        // Single glyph from producer 2, engine done 10 cycles after flag.
        req_ascii[14 +: 7] = 7'd16;
        req_x[18 +: 9]     = 9'd32;
        req_y[18 +: 9]     = 9'd48;
        req_size[2]        = 1'b1;
        req                = 4'b0100;
        wait_flag();
        check("t2_ascii", 32'(ascii_num), 32'd16);
        check("t2_x", 32'(start_x), 32'd32);
        check("t2_y", 32'(start_y), 32'd48);
        check("t2_size", 32'(en_size), 32'd1);
        stable = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (ascii_num != 7'd16 || start_x != 9'd32 || start_y != 9'd48) stable = 1'b0;
            if (ack != 4'd0 || show_char_flag) stable = 1'b0;
        end
        check("t2_stable", 32'(stable), 32'd1);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("t2_ack", 32'(ack), 32'h4);
        check("t2_err", 32'(ack_err), 32'd0);
        tick();
        check("t2_ack_pulse", 32'(ack), 32'd0);
        req = '0;
        tick();
        check("t2_mask_no_regrant", 32'(busy), 32'd0);
        check("t2_hold_ascii", 32'(ascii_num), 32'd16);

        // Round robin with all requests held, from a fresh pointer.
        do_reset();
        init_done    = 1'b1;
        req          = 4'b1111;
        exp_order[0] = 4'b0001;
        exp_order[1] = 4'b0010;
        exp_order[2] = 4'b0100;
        exp_order[3] = 4'b1000;
        exp_order[4] = 4'b0001;
        exp_order[5] = 4'b0010;
        for (int g = 0; g < 6; g++) begin
            glyph(2, a, e, n, asc);
            check($sformatf("rr_ack%0d", g), 32'(a), 32'(exp_order[g]));
            check($sformatf("rr_lat%0d", g), 32'(n), 32'd3);
        end
        req = '0;

        // Watchdog abort on producer 0, then producer 3 still served.
        req_ascii[0 +: 7]  = 7'h41;
        req_ascii[21 +: 7] = 7'h65;
        req                = 4'b0001;
        glyph(0, a, e, n, asc);
        check("to_ack", 32'(a), 32'h1);
        check("to_err", 32'(e), 32'd1);
        check("to_cycles", 32'(n), 32'd20);
        check("to_ascii", 32'(asc), 32'h41);
        req = 4'b1000;
        glyph(3, a, e, n, asc);
        check("after_to_ack", 32'(a), 32'h8);
        check("after_to_err", 32'(e), 32'd0);
        check("after_to_lat", 32'(n), 32'd4);
        check("after_to_ascii", 32'(asc), 32'h65);

        // Done pulse during the flag cycle must be ignored.
        req = 4'b0100;
        wait_flag();
        done = 1'b1;
        tick();
        done = 1'b0;
        check("issue_done_ignored", 32'(ack), 32'd0);
        check("issue_busy", 32'(busy), 32'd1);
        repeat (3) tick();
        check("busy_no_ack", 32'(ack), 32'd0);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("t5_ack", 32'(ack), 32'h4);
        req = '0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ack != 4'd0) cnt++;
        end
        check("t5_single_ack", 32'(cnt), 32'd0);

        // init_done dropped mid-BUSY, then restored.
        req_ascii[0 +: 7] = 7'h2A;
        req               = 4'b0001;
        wait_flag();
        repeat (3) tick();
        init_done = 1'b0;
        tick();
        check("drop_busy", 32'(busy), 32'd0);
        check("drop_ack", 32'(ack), 32'd0);
        seen = 1'b0;
        done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            done = 1'b0;
            if (show_char_flag || (ack != 4'd0) || busy) seen = 1'b1;
        end
        check("drop_quiet", 32'(seen), 32'd0);
        check("drop_hold_ascii", 32'(ascii_num), 32'h2A);
        init_done = 1'b1;
        glyph(2, a, e, n, asc);
        check("restore_ack", 32'(a), 32'h1);
        check("restore_err", 32'(e), 32'd0);
        check("restore_ascii", 32'(asc), 32'h2A);
        req = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
